// File: rtl/s3g_tx.sv
`timescale 1ns/1ps
// s3g_tx: latches one response payload and sends it to the UART as
// START_BYTE, L, payload[0..L-1], CRC8 (Maxim, reflected 0x8C, init 0).
module s3g_tx #(
  parameter logic [7:0] START_BYTE = 8'hD5,
  parameter int         MAX_LEN    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       packet_wr,
  input  logic [7:0] payload_len,
  input  logic [7:0] buf0,
  input  logic [7:0] buf1,
  input  logic [7:0] buf2,
  input  logic [7:0] buf3,
  input  logic [7:0] buf4,
  input  logic [7:0] buf5,
  input  logic [7:0] buf6,
  input  logic [7:0] buf7,
  input  logic [7:0] buf8,
  input  logic [7:0] buf9,
  input  logic [7:0] buf10,
  input  logic [7:0] buf11,
  input  logic [7:0] buf12,
  input  logic [7:0] buf13,
  input  logic [7:0] buf14,
  input  logic [7:0] buf15,
  output logic       busy,
  output logic [7:0] uart_data,
  output logic       uart_wr,
  input  logic       uart_busy
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int LW = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_LEN, S_DATA, S_CRC, S_WAIT
  } state_t;

  state_t        state, state_d, ret_q, ret_d;
  logic [7:0]    pay_q [MAX_LEN];
  logic [7:0]    buf_in [16];
  logic [LW-1:0] len_q, len_in;
  logic [IW-1:0] idx_q;
  logic [7:0]    crc_q, hold_q, tx_byte;
  logic          send;

  assign buf_in = '{buf0, buf1, buf2, buf3, buf4, buf5, buf6, buf7,
                    buf8, buf9, buf10, buf11, buf12, buf13, buf14, buf15};

  function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] x;
    x = c ^ d;
    for (int i = 0; i < 8; i++) begin
      x = x[0] ? ((x >> 1) ^ 8'h8C) : (x >> 1);
    end
    return x;
  endfunction

  always_comb begin
    len_in = (payload_len > 8'(MAX_LEN)) ? LW'(MAX_LEN) : payload_len[LW-1:0];
  end

  // Handshake: uart_wr is a one-cycle strobe issued only while uart_busy=0,
  // uart_data is valid in that same cycle, and the UART may raise uart_busy
  // up to one cycle later -- S_WAIT absorbs that latency before the next send.
  always_comb begin
    state_d = state;
    ret_d   = ret_q;
    send    = 1'b0;
    tx_byte = hold_q;
    case (state)
      S_IDLE: if (packet_wr) state_d = S_START;
      S_START: begin
        tx_byte = START_BYTE;
        ret_d   = S_LEN;
        send    = !uart_busy;
      end
      S_LEN: begin
        tx_byte = 8'(len_q);
        ret_d   = (len_q != '0) ? S_DATA : S_CRC;
        send    = !uart_busy;
      end
      S_DATA: begin
        tx_byte = pay_q[idx_q];
        ret_d   = (LW'(idx_q) == len_q - LW'(1)) ? S_CRC : S_DATA;
        send    = !uart_busy;
      end
      S_CRC: begin
        tx_byte = crc_q;
        ret_d   = S_IDLE;
        send    = !uart_busy;
      end
      S_WAIT:  state_d = ret_q;
      default: state_d = S_IDLE;
    endcase
    if (send) state_d = S_WAIT;
    else      ret_d   = ret_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      ret_q  <= S_IDLE;
      busy   <= 1'b0;
      len_q  <= '0;
      idx_q  <= '0;
      crc_q  <= 8'h00;
      hold_q <= 8'h00;
      for (int i = 0; i < MAX_LEN; i++) pay_q[i] <= 8'h00;
    end else begin
      state <= state_d;
      ret_q <= ret_d;
      busy  <= (state_d != S_IDLE);
      if (state == S_IDLE && packet_wr) begin
        len_q <= len_in;
        idx_q <= '0;
        crc_q <= 8'h00;
        for (int i = 0; i < MAX_LEN; i++) pay_q[i] <= buf_in[i];
      end
      if (send) begin
        hold_q <= tx_byte;
        if (state == S_DATA) begin
          crc_q <= crc8_upd(crc_q, tx_byte);
          idx_q <= idx_q + IW'(1);
        end
      end
    end
  end

  // rst gates the strobe so an abandoned frame never emits a byte.
  assign uart_wr   = send && !rst;
  assign uart_data = uart_wr ? tx_byte : hold_q;

endmodule

// File: tb/tb_s3g_tx.sv
`timescale 1ns/1ps
// tb_s3g_tx: directed frames against a frame-level model with per-cycle
// checks of uart_wr, uart_data and busy, plus literal expected frames.
module tb_s3g_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       packet_wr = 1'b0;
  logic [7:0] payload_len = 8'h00;
  logic [7:0] pbuf [16];
  logic       busy;
  logic [7:0] uart_data;
  logic       uart_wr;
  logic       uart_busy = 1'b0;
  logic       bp_en = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int eligible = 0;
  int acc_cyc = 0;
  int end_cnt = 0;
  logic m_busy = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int rx_cyc_q[$];

  always #5 clk = ~clk;

  s3g_tx dut (
    .clk(clk), .rst(rst), .packet_wr(packet_wr), .payload_len(payload_len),
    .buf0(pbuf[0]), .buf1(pbuf[1]), .buf2(pbuf[2]), .buf3(pbuf[3]),
    .buf4(pbuf[4]), .buf5(pbuf[5]), .buf6(pbuf[6]), .buf7(pbuf[7]),
    .buf8(pbuf[8]), .buf9(pbuf[9]), .buf10(pbuf[10]), .buf11(pbuf[11]),
    .buf12(pbuf[12]), .buf13(pbuf[13]), .buf14(pbuf[14]), .buf15(pbuf[15]),
    .busy(busy), .uart_data(uart_data), .uart_wr(uart_wr), .uart_busy(uart_busy)
  );

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bit-serial Maxim CRC8: LSB first, feedback into reflected poly 0x8C.
  function automatic logic [7:0] crc_model(input logic [7:0] d[$]);
    logic [7:0] c;
    logic fb;
    c = 8'h00;
    foreach (d[k]) begin
      for (int i = 0; i < 8; i++) begin
        fb = c[0] ^ d[k][i];
        c = c >> 1;
        if (fb) c = c ^ 8'h8C;
      end
    end
    return c;
  endfunction

  function automatic void push_frame();
    logic [7:0] pl[$];
    int l;
    l = (payload_len > 8'd16) ? 16 : int'(payload_len);
    for (int i = 0; i < l; i++) pl.push_back(pbuf[i]);
    exp_q.push_back(8'hD5);
    exp_q.push_back(8'(l));
    foreach (pl[i]) exp_q.push_back(pl[i]);
    exp_q.push_back(crc_model(pl));
  endfunction

  // Scoreboard: a frame becomes a byte queue; a byte is due once the 2-cycle
  // spacing has elapsed and uart_busy is low; busy ends 2 cycles after the CRC.
  always @(negedge clk) begin
    logic exp_wr;
    logic cur_busy;
    logic [7:0] b;
    if (rst) begin
      exp_q.delete();
      m_busy  = 1'b0;
      end_cnt = 0;
    end else begin
      cur_busy = m_busy;
      exp_wr = (exp_q.size() > 0) && (cyc >= eligible) && !uart_busy;
      chk(busy === cur_busy, "busy", int'(busy), int'(cur_busy));
      chk(uart_wr === exp_wr, "uart_wr", int'(uart_wr), int'(exp_wr));
      if (end_cnt > 0) begin
        end_cnt--;
        if (end_cnt == 0) m_busy = 1'b0;
      end
      if (uart_wr) begin
        rx_q.push_back(uart_data);
        rx_cyc_q.push_back(cyc);
        if (exp_q.size() > 0) begin
          b = exp_q.pop_front();
          chk(uart_data === b, "uart_data", int'(uart_data), int'(b));
          eligible = cyc + 2;
          if (exp_q.size() == 0) end_cnt = 1;
        end
      end
      if (packet_wr && !cur_busy) begin
        push_frame();
        m_busy   = 1'b1;
        eligible = cyc + 1;
        acc_cyc  = cyc;
      end
    end
    cyc++;
  end

  // UART back-pressure: hold uart_busy high for 5 cycles after each strobe.
  always begin
    @(negedge clk);
    if (bp_en && uart_wr) begin
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        uart_busy = 1'b1;
      end
      @(posedge clk); #1;
      uart_busy = 1'b0;
    end
  end

  task automatic send_pkt(input int len);
    @(posedge clk); #1;
    payload_len = 8'(len);
    packet_wr = 1'b1;
    @(posedge clk); #1;
    packet_wr = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(m_busy == 1'b0 && exp_q.size() == 0 && busy == 1'b0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) chk(1'b0, "idle_timeout", n, budget);
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input string name, input logic [7:0] exp[$]);
    chk(rx_q.size() == exp.size(), {name, "_len"}, rx_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
      chk(rx_q[i] === exp[i], {name, "_byte"}, int'(rx_q[i]), int'(exp[i]));
    rx_q.delete();
    rx_cyc_q.delete();
  endtask

  task automatic set_buf(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    for (int i = 0; i < 16; i++) pbuf[i] = 8'h00;
    pbuf[0] = b0;
    pbuf[1] = b1;
    pbuf[2] = b2;
  endtask

  initial begin
    logic [7:0] q[$];
    int n;
    set_buf(8'h00, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    chk(busy === 1'b0, "rst_busy", int'(busy), 0);
    chk(uart_wr === 1'b0, "rst_uart_wr", int'(uart_wr), 0);
    chk(uart_data === 8'h00, "rst_uart_data", int'(uart_data), 0);
    rst = 1'b0;

    q = {8'h81};
    chk(crc_model(q) == 8'hD2, "model_crc_ok", int'(crc_model(q)), 'hD2);
    q = {8'h81, 8'hBA, 8'hCE};
    chk(crc_model(q) == 8'hF9, "model_crc_ver", int'(crc_model(q)), 'hF9);

    // empty payload, with pulse timing relative to the write cycle
    send_pkt(0);
    wait_idle(100);
    if (rx_cyc_q.size() == 3) begin
      chk(rx_cyc_q[0] == acc_cyc + 1, "empty_t0", rx_cyc_q[0] - acc_cyc, 1);
      chk(rx_cyc_q[1] == acc_cyc + 3, "empty_t1", rx_cyc_q[1] - acc_cyc, 3);
      chk(rx_cyc_q[2] == acc_cyc + 5, "empty_t2", rx_cyc_q[2] - acc_cyc, 5);
    end
    q = {8'hD5, 8'h00, 8'h00};
    expect_frame("empty", q);

    set_buf(8'h81, 8'h00, 8'h00);
    send_pkt(1);
    wait_idle(100);
    q = {8'hD5, 8'h01, 8'h81, 8'hD2};
    expect_frame("ok", q);

    set_buf(8'h81, 8'hBA, 8'hCE);
    send_pkt(3);
    wait_idle(100);
    q = {8'hD5, 8'h03, 8'h81, 8'hBA, 8'hCE, 8'hF9};
    expect_frame("version", q);

    bp_en = 1'b1;
    send_pkt(3);
    wait_idle(300);
    bp_en = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    expect_frame("backpressure", q);

    // second write mid-frame with changed inputs must be dropped
    send_pkt(3);
    repeat (3) @(posedge clk);
    #1;
    set_buf(8'h55, 8'h66, 8'h77);
    send_pkt(1);
    wait_idle(100);
    repeat (10) @(posedge clk);
    #1;
    expect_frame("ignored_wr", q);

    for (int i = 0; i < 16; i++) pbuf[i] = 8'(i);
    send_pkt(20);
    wait_idle(200);
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(8'(i));
    q.push_front(8'h10);
    q.push_front(8'hD5);
    q.push_back(crc_model(q[2:17]));
    expect_frame("clamp", q);

    // reset after the second payload byte abandons the frame
    send_pkt(20);
    n = 0;
    while (rx_q.size() < 4 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk(1'b0, "rst_wait_timeout", n, 100);
    rst = 1'b1;
    @(posedge clk); #1;
    chk(busy === 1'b0, "midrst_busy", int'(busy), 0);
    chk(uart_wr === 1'b0, "midrst_uart_wr", int'(uart_wr), 0);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk(rx_q.size() == 4, "midrst_bytes", rx_q.size(), 4);
    rx_q.delete();
    rx_cyc_q.delete();
    set_buf(8'h81, 8'h00, 8'h00);
    send_pkt(1);
    wait_idle(100);
    q = {8'hD5, 8'h01, 8'h81, 8'hD2};
    expect_frame("after_rst", q);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
